opcode_sequencer: RTL
=====================

Name: opcode_sequencer

Overview:
Parametrised, programmable opcode stimulus generator for the single-cycle datapath bench and bring-up. A loadable table of up to DEPTH opcodes is played out to the decoder over a valid/ready handshake. Three modes are supported: run-once, continuous loop and single-step. The block replaces fixed hard-coded opcode walkers, and reports progress through an index, a done flag and a loop counter.

Parameters:
OPW, 4, opcode width in bits
DEPTH, 8, number of table entries (power of 2, minimum 2)
AW, 3, table address width; must equal log2(DEPTH)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  table write strobe
cfg_addr  in  AW  table write address
cfg_data  in  OPW  table write data
seq_len  in  AW+1  number of entries to play; sampled on start
mode  in  2  00 once, 01 loop, 10 step, 11 reserved (treated as once)
start  in  1  single-cycle pulse that begins playback
step  in  1  single-cycle pulse that releases the next entry in step mode
stop  in  1  single-cycle pulse that aborts playback
op_ready  in  1  consumer accepts OPCODE
OPCODE  out  OPW  current opcode (registered)
op_valid  out  1  OPCODE/op_index valid
op_index  out  AW  table index of the current OPCODE
busy  out  1  high in RUN or HOLD
done  out  1  high in DONE
wrap_cnt  out  8  completed loop passes, saturating at 255

Behaviour:
- Reset (async assert, sync deassert by the system): state IDLE; OPCODE=0, op_valid=0, op_index=0, busy=0, done=0, wrap_cnt=0; all table entries=0.
- Table writes: when cfg_we=1 and the state is IDLE or DONE, entry[cfg_addr]<=cfg_data. Writes while busy are ignored.
- len_q latch on start: len_q = seq_len if 1<=seq_len<=DEPTH, otherwise DEPTH. mode_q is latched at the same time; mode changes mid-run have no effect.
- States: IDLE, RUN, HOLD, DONE.
- IDLE/DONE + start: the next cycle enters RUN with op_valid=1, op_index=0, OPCODE=entry[0] (latency of 1 clock). wrap_cnt clears to 0 on start.
- Handshake: in RUN, OPCODE, op_index and op_valid are held stable until op_valid&op_ready. No entry is skipped or repeated.
- On accept of index i<len_q-1:
  - once/loop: the next cycle presents i+1, giving back-to-back throughput of one per clock.
  - step: enter HOLD with op_valid=0 and op_index/OPCODE held.
- HOLD + step: the next cycle enters RUN presenting i+1, or the wrap target. A step pulse in RUN or IDLE is ignored.
- On accept of index len_q-1:
  - once: enter DONE with op_valid=0 and done=1.
  - loop: the next cycle presents index 0; wrap_cnt increments, saturating at 255.
  - step: enter HOLD; the following step wraps to index 0 and increments wrap_cnt.
- stop (any state): the next cycle enters IDLE with op_valid=0, busy=0, done=0. If stop coincides with a handshake, that transfer counts as completed but nothing further is issued. stop has priority over start and step in the same cycle.
- start while busy is ignored.
- Table contents are read combinationally at the registered next index. A table write never races playback, because writes are blocked while busy.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Load entries 0..7 = 3,0,1,7,8,A,E,F; seq_len=8; mode=once; op_ready=1; pulse start → op_valid high 1 clk after start. OPCODE sequence is 3,0,1,7,8,A,E,F on 8 consecutive clocks. done=1 and op_valid=0 on the 9th clock.
- Same table, mode=loop, seq_len=3, op_ready=1 for 10 clks → OPCODE sequence is 3,0,1,3,0,1,3,0,1,3. wrap_cnt=3 after the 9th accept.
- Backpressure, mode=once: op_ready held low 4 clks on index 2 → OPCODE=1 and op_index=2 stay stable for all 4 clks. No skip occurs after op_ready rises.
- Step mode, seq_len=2: start → OPCODE=3 is presented; after accept op_valid=0 until step; step → 0; step → wraps to 3, and wrap_cnt=1.
- Boundaries: seq_len=0 and seq_len=12 each play all 8 entries. Then issue stop in the same cycle as the accept of index 4 in loop mode → IDLE next clock and op_valid=0. A cfg_we attempted while busy leaves the table unchanged (verified by the next run).
- Assert rst_n low mid-RUN asynchronously → outputs go to reset values immediately without a clock. After release, the table reads all-zero until reloaded.

Source files
------------

// File: rtl/opcode_sequencer.sv
// opcode_sequencer: programmable opcode table played out over a valid/ready handshake
module opcode_sequencer #(
    parameter int OPW   = 4,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_we,
    input  logic [AW-1:0]  cfg_addr,
    input  logic [OPW-1:0] cfg_data,
    input  logic [AW:0]    seq_len,
    input  logic [1:0]     mode,
    input  logic           start,
    input  logic           step,
    input  logic           stop,
    input  logic           op_ready,
    output logic [OPW-1:0] OPCODE,
    output logic           op_valid,
    output logic [AW-1:0]  op_index,
    output logic           busy,
    output logic           done,
    output logic [7:0]     wrap_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);
    state_t         state, nxt_state;
    logic [OPW-1:0] tbl [DEPTH];
    logic [AW:0]    len_q, nxt_len;
    logic [1:0]     mode_q;
    logic [AW-1:0]  nxt_idx;
    logic [7:0]     nxt_wrap, wrap_inc;
    logic           idle_like, last, launch;
    assign idle_like = (state == IDLE) || (state == DONE);
    assign launch    = idle_like && start && !stop;
    assign last      = ({1'b0, op_index} == len_q - ONE);
    assign wrap_inc  = (wrap_cnt == 8'hFF) ? wrap_cnt : wrap_cnt + 8'd1;
    assign nxt_len   = (seq_len != '0 && seq_len <= LEN_MAX) ? seq_len : LEN_MAX;
    // table storage, writable only while playback is not active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
        end else if (cfg_we && idle_like) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end
    // state register plus the registered playback outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_index <= '0;
            wrap_cnt <= '0;
            OPCODE   <= '0;
            len_q    <= LEN_MAX;
            mode_q   <= 2'b00;
        end else begin
            state    <= nxt_state;
            op_index <= nxt_idx;
            wrap_cnt <= nxt_wrap;
            OPCODE   <= (nxt_state == RUN) ? tbl[nxt_idx] : OPCODE;
            len_q    <= launch ? nxt_len : len_q;
            mode_q   <= launch ? mode : mode_q;
        end
    end
    // next state, next index and wrap count; stop overrides everything
    always_comb begin
        nxt_state = state;
        nxt_idx   = op_index;
        nxt_wrap  = wrap_cnt;
        if (stop) begin
            nxt_state = IDLE;
        end else if (idle_like && start) begin
            nxt_state = RUN;
            nxt_idx   = '0;
            nxt_wrap  = '0;
        end else if (state == RUN && op_ready) begin
            if (mode_q == 2'b10) begin
                nxt_state = HOLD;
            end else if (!last) begin
                nxt_idx = op_index + 1'b1;
            end else if (mode_q == 2'b01) begin
                nxt_idx  = '0;
                nxt_wrap = wrap_inc;
            end else begin
                nxt_state = DONE;
            end
        end else if (state == HOLD && step) begin
            nxt_state = RUN;
            nxt_idx   = last ? '0 : op_index + 1'b1;
            nxt_wrap  = last ? wrap_inc : wrap_cnt;
        end
    end
    // status flags decoded from the state register only
    always_comb begin
        op_valid = (state == RUN);
        busy     = (state == RUN) || (state == HOLD);
        done     = (state == DONE);
    end
endmodule
